// File: rtl/forward_control_unit.sv
// -----------------------------------------------------------------------------
// forward_control_unit
//
// Forwarding and load-use hazard controller for the pipelined RISC core.
// The ID-stage source registers are compared against the destinations of the
// instructions currently in EX and MEM. A registered 2-bit forward select per
// source channel is produced for the EX operand muxes in the following cycle.
// A load in EX whose destination is read by the ID instruction holds the front
// end for LOAD_STALL cycles.
//
// Parameters
//   NUM_SRC     number of source operand channels per instruction
//   REG_ADDR_W  register address width
//   LOAD_STALL  stall cycles inserted per load-use hazard (>= 1)
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   flush          pipeline flush (branch taken / exception)
//   id_valid       ID stage holds a valid instruction
//   id_src_addr    ID source registers, channel i at [i*REG_ADDR_W +: REG_ADDR_W]
//   id_src_used    channel i actually reads its register
//   ex_*           EX stage valid / reg write / load / destination
//   mem_*          MEM stage valid / reg write / destination
//   fwd_sel        registered per-channel select: 0 regfile, 1 EX/MEM, 2 MEM/WB
//   stall          hold PC and IF/ID register
//   bubble         insert NOP into ID/EX (same as stall)
//   hazard_cnt     saturating count of load-use hazards detected
// -----------------------------------------------------------------------------
module forward_control_unit #(
  parameter int NUM_SRC    = 2,
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_STALL = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic                          ex_valid,
  input  logic                          ex_reg_write,
  input  logic                          ex_mem_read,
  input  logic [REG_ADDR_W-1:0]         ex_dst_addr,
  input  logic                          mem_valid,
  input  logic                          mem_reg_write,
  input  logic [REG_ADDR_W-1:0]         mem_dst_addr,
  output logic [NUM_SRC*2-1:0]          fwd_sel,
  output logic                          stall,
  output logic                          bubble,
  output logic [15:0]                   hazard_cnt
);

  localparam int SCNT_W = $clog2(LOAD_STALL + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SCNT_W-1:0]      scnt_q, scnt_d;
  logic [NUM_SRC*2-1:0]   fwd_sel_q, fwd_sel_d;
  logic [15:0]            hazard_cnt_q, hazard_cnt_d;

  logic [NUM_SRC-1:0]     m_ex;
  logic [NUM_SRC-1:0]     m_mem;
  logic [NUM_SRC*2-1:0]   next_sel;
  logic                   haz;
  logic                   stall_int;

  // Per-channel match terms. Register 0 is hardwired zero and never forwarded.
  // EX wins over MEM because it holds the newer value of the register.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_ch
    logic [REG_ADDR_W-1:0] src;
    assign src      = id_src_addr[g*REG_ADDR_W +: REG_ADDR_W];
    assign m_ex[g]  = ex_valid & ex_reg_write & id_src_used[g] &
                      (src == ex_dst_addr) & (|src);
    assign m_mem[g] = mem_valid & mem_reg_write & id_src_used[g] &
                      (src == mem_dst_addr) & (|src);
    assign next_sel[2*g +: 2] = m_ex[g]  ? 2'd1 :
                                m_mem[g] ? 2'd2 : 2'd0;
  end

  // A load in EX cannot forward its result in time for an ID reader.
  assign haz = id_valid & ex_mem_read & (|m_ex);

  // Stall FSM. IDLE raises stall in the same cycle as the hazard; HOLD covers
  // the remaining LOAD_STALL-1 cycles. A flush cancels any stall outright,
  // since the instruction that would be stalled is being discarded.
  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    stall_int = 1'b0;
    case (state_q)
      IDLE: begin
        stall_int = haz;
        if (haz && (LOAD_STALL > 1)) begin
          state_d = HOLD;
          scnt_d  = SCNT_W'(LOAD_STALL - 1);
        end
      end
      HOLD: begin
        stall_int = 1'b1;
        scnt_d    = scnt_q - SCNT_W'(1);
        if (scnt_q == SCNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        scnt_d  = '0;
      end
    endcase
    if (flush) begin
      state_d   = IDLE;
      scnt_d    = '0;
      stall_int = 1'b0;
    end
  end

  // While stalling, a bubble enters EX, so nothing must be forwarded to it.
  always_comb begin
    fwd_sel_d = next_sel;
    if (flush || stall_int) begin
      fwd_sel_d = '0;
    end
  end

  // Each hazard is counted once, on the IDLE cycle that detects it.
  always_comb begin
    hazard_cnt_d = hazard_cnt_q;
    if ((state_q == IDLE) && stall_int && (hazard_cnt_q != 16'hFFFF)) begin
      hazard_cnt_d = hazard_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      scnt_q       <= '0;
      fwd_sel_q    <= '0;
      hazard_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      scnt_q       <= scnt_d;
      fwd_sel_q    <= fwd_sel_d;
      hazard_cnt_q <= hazard_cnt_d;
    end
  end

  // Gating with rst drops stall immediately on an asynchronous reset, even
  // while the registered state has not yet been observed as IDLE downstream.
  assign stall      = stall_int & ~rst;
  assign bubble     = stall;
  assign fwd_sel    = fwd_sel_q;
  assign hazard_cnt = hazard_cnt_q;

endmodule

// File: tb/tb_forward_control_unit.sv
// -----------------------------------------------------------------------------
// tb_forward_control_unit
//
// Directed testbench for forward_control_unit. Two instances share one set of
// stimulus: dut_a uses a single stall cycle per load-use hazard, dut_b uses
// three. Expected values are hand-computed for each vector.
// -----------------------------------------------------------------------------
module tb_forward_control_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        id_valid;
  logic [9:0]  id_src_addr;
  logic [1:0]  id_src_used;
  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [4:0]  ex_dst_addr;
  logic        mem_valid;
  logic        mem_reg_write;
  logic [4:0]  mem_dst_addr;

  logic [3:0]  fwd_sel_a, fwd_sel_b;
  logic        stall_a, stall_b;
  logic        bubble_a, bubble_b;
  logic [15:0] hazard_cnt_a, hazard_cnt_b;

  int passCount;
  int checkCount;

  forward_control_unit #(.NUM_SRC(2), .REG_ADDR_W(5), .LOAD_STALL(1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_dst_addr(ex_dst_addr), .mem_valid(mem_valid),
    .mem_reg_write(mem_reg_write), .mem_dst_addr(mem_dst_addr),
    .fwd_sel(fwd_sel_a), .stall(stall_a), .bubble(bubble_a),
    .hazard_cnt(hazard_cnt_a)
  );

  forward_control_unit #(.NUM_SRC(2), .REG_ADDR_W(5), .LOAD_STALL(3)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_dst_addr(ex_dst_addr), .mem_valid(mem_valid),
    .mem_reg_write(mem_reg_write), .mem_dst_addr(mem_dst_addr),
    .fwd_sel(fwd_sel_b), .stall(stall_b), .bubble(bubble_b),
    .hazard_cnt(hazard_cnt_b)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and keep the tally.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  // Drive one full set of pipeline inputs (flush is driven separately).
  task automatic applyStimulus(input logic vld, input logic [4:0] s0,
                               input logic [4:0] s1, input logic [1:0] used,
                               input logic exv, input logic exw,
                               input logic exm, input logic [4:0] exd,
                               input logic memv, input logic memw,
                               input logic [4:0] memd);
    id_valid      = vld;
    id_src_addr   = {s1, s0};
    id_src_used   = used;
    ex_valid      = exv;
    ex_reg_write  = exw;
    ex_mem_read   = exm;
    ex_dst_addr   = exd;
    mem_valid     = memv;
    mem_reg_write = memw;
    mem_dst_addr  = memd;
  endtask

  // Advance to just after the next rising edge, away from the sampling point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence: reset, forwarding priority, load-use stalls for both
  // stall lengths, flush behaviour, async reset mid-stall and saturation.
  initial begin
    passCount  = 0;
    checkCount = 0;
    rst        = 1'b1;
    flush      = 1'b0;
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);

    #12;
    checkOutput("rst_fwd_a",  32'(fwd_sel_a),    32'h0);
    checkOutput("rst_stall_a", 32'(stall_a),     32'h0);
    checkOutput("rst_hcnt_a", 32'(hazard_cnt_a), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // ch0=5 matches both EX and MEM: EX wins. ch1=6 matches nothing.
    applyStimulus(1, 5, 6, 2'b11, 1, 1, 0, 5, 1, 1, 5);
    #1;
    checkOutput("ex_prio_stall", 32'(stall_a), 32'h0);
    tick();
    checkOutput("ex_prio_sel", 32'(fwd_sel_a), 32'h1);

    // ch1=7 matches MEM only; ch0=r0 never forwards even with ex_dst=r0.
    applyStimulus(1, 0, 7, 2'b11, 1, 1, 0, 0, 1, 1, 7);
    tick();
    checkOutput("mem_sel_a", 32'(fwd_sel_a), 32'h8);
    checkOutput("mem_sel_b", 32'(fwd_sel_b), 32'h8);

    // Matching register on unused channels: no forward, no stall.
    applyStimulus(1, 9, 9, 2'b00, 1, 1, 1, 9, 0, 0, 0);
    #1;
    checkOutput("unused_stall_a", 32'(stall_a), 32'h0);
    checkOutput("unused_stall_b", 32'(stall_b), 32'h0);
    tick();
    checkOutput("unused_sel_a", 32'(fwd_sel_a), 32'h0);

    // Load-use shape but id_valid=0: no stall, select still computed.
    applyStimulus(0, 9, 0, 2'b01, 1, 1, 1, 9, 0, 0, 0);
    #1;
    checkOutput("novalid_stall_a", 32'(stall_a), 32'h0);
    checkOutput("novalid_stall_b", 32'(stall_b), 32'h0);
    tick();
    checkOutput("novalid_sel_a", 32'(fwd_sel_a), 32'h1);

    // Load to r3 in EX, ID reads r3.
    applyStimulus(1, 3, 0, 2'b01, 1, 1, 1, 3, 0, 0, 0);
    #1;
    checkOutput("lu1_stall_a",  32'(stall_a),  32'h1);
    checkOutput("lu1_bubble_a", 32'(bubble_a), 32'h1);
    checkOutput("lu1_stall_b",  32'(stall_b),  32'h1);
    tick();
    checkOutput("lu1_sel_bubble_a", 32'(fwd_sel_a), 32'h0);
    // Load has moved to MEM, EX holds the bubble.
    applyStimulus(1, 3, 0, 2'b01, 0, 0, 0, 0, 1, 1, 3);
    #1;
    checkOutput("lu1_release_a",  32'(stall_a),  32'h0);
    checkOutput("lu1_nobubble_a", 32'(bubble_a), 32'h0);
    checkOutput("lu1_hold_b",     32'(stall_b),  32'h1);
    tick();
    checkOutput("lu1_sel_mem_a", 32'(fwd_sel_a),    32'h2);
    checkOutput("lu1_hcnt_a",    32'(hazard_cnt_a), 32'h1);
    checkOutput("lu3_last_b",    32'(stall_b),      32'h1);

    // Asynchronous reset while dut_b is still stalling.
    rst = 1'b1;
    #1;
    checkOutput("arst_sel_a",    32'(fwd_sel_a),    32'h0);
    checkOutput("arst_hcnt_a",   32'(hazard_cnt_a), 32'h0);
    checkOutput("arst_stall_b",  32'(stall_b),      32'h0);
    checkOutput("arst_bubble_b", 32'(bubble_b),     32'h0);
    #1;
    rst = 1'b0;
    tick();

    // Three-cycle load-use on dut_b.
    applyStimulus(1, 3, 0, 2'b01, 1, 1, 1, 3, 0, 0, 0);
    #1;
    checkOutput("lu3_c0_b", 32'(stall_b), 32'h1);
    tick();
    applyStimulus(1, 3, 0, 2'b01, 0, 0, 0, 0, 1, 1, 3);
    #1;
    checkOutput("lu3_c1_b",     32'(stall_b),   32'h1);
    checkOutput("lu3_c1_sel_b", 32'(fwd_sel_b), 32'h0);
    tick();
    checkOutput("lu3_c2_b", 32'(stall_b), 32'h1);
    tick();
    checkOutput("lu3_c3_b",   32'(stall_b),      32'h0);
    checkOutput("lu3_hcnt_b", 32'(hazard_cnt_b), 32'h1);
    tick();
    checkOutput("lu3_sel_mem_b", 32'(fwd_sel_b), 32'h2);

    // Flush in the second stall cycle of dut_b.
    applyStimulus(1, 3, 0, 2'b01, 1, 1, 1, 3, 0, 0, 0);
    #1;
    checkOutput("fl_c0_b", 32'(stall_b), 32'h1);
    tick();
    applyStimulus(1, 3, 0, 2'b01, 0, 0, 0, 0, 1, 1, 3);
    flush = 1'b1;
    #1;
    checkOutput("fl_stall_b", 32'(stall_b), 32'h0);
    tick();
    flush = 1'b0;
    checkOutput("fl_sel_b", 32'(fwd_sel_b), 32'h0);
    #1;
    checkOutput("fl_idle_b", 32'(stall_b),      32'h0);
    checkOutput("fl_hcnt_b", 32'(hazard_cnt_b), 32'h2);

    // Flush together with a fresh hazard: no stall, not counted.
    applyStimulus(1, 3, 0, 2'b01, 1, 1, 1, 3, 0, 0, 0);
    flush = 1'b1;
    #1;
    checkOutput("flhaz_stall_a", 32'(stall_a), 32'h0);
    tick();
    flush = 1'b0;
    checkOutput("flhaz_hcnt_a", 32'(hazard_cnt_a), 32'h2);

    // Continuous hazard on dut_a drives the counter into saturation.
    for (int i = 0; i < 65536; i++) begin
      tick();
    end
    checkOutput("sat_hcnt_a",  32'(hazard_cnt_a), 32'hFFFF);
    checkOutput("sat_stall_a", 32'(stall_a),      32'h1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
